// File: rtl/multi_zone_irrigation_ctrl_if.sv
// Sensor inputs and valve/status outputs of the multi-zone irrigation controller.
// master = sensor/driver side, slave = controller.
interface multi_zone_irrigation_ctrl_if #(
    parameter int N_ZONES = 4
);
    logic               high_level_indicator_i;
    logic               middle_level_indicator_i;
    logic               low_level_indicator_i;
    logic [N_ZONES-1:0] soil_dry_i;
    logic [N_ZONES-1:0] temp_high_i;
    logic [N_ZONES-1:0] zone_enable_i;
    logic               inlet_valve_o;
    logic               error_indicator_o;
    logic               alarm_state_o;
    logic [N_ZONES-1:0] sprinkler_valve_o;
    logic [N_ZONES-1:0] drip_valve_o;
    logic [2:0]         active_zone_o;
    logic               busy_o;

    modport master (
        output high_level_indicator_i, middle_level_indicator_i, low_level_indicator_i,
        output soil_dry_i, temp_high_i, zone_enable_i,
        input  inlet_valve_o, error_indicator_o, alarm_state_o,
        input  sprinkler_valve_o, drip_valve_o, active_zone_o, busy_o
    );

    modport slave (
        input  high_level_indicator_i, middle_level_indicator_i, low_level_indicator_i,
        input  soil_dry_i, temp_high_i, zone_enable_i,
        output inlet_valve_o, error_indicator_o, alarm_state_o,
        output sprinkler_valve_o, drip_valve_o, active_zone_o, busy_o
    );
endinterface

// File: rtl/multi_zone_irrigation_ctrl.sv
// Round-robin shared-pump irrigation scheduler with tank supervision; optional DEBOUNCE_EN sensor filter.
// Latency: 2-FF sync (+DEBOUNCE_CYCLES if DEBOUNCE_EN) plus one registered output stage; no backpressure.
module multi_zone_irrigation_ctrl #(
    parameter int N_ZONES         = 4,
    parameter int TIMER_W         = 16,
    parameter int SPRINKLE_CYCLES = 1000,
    parameter int DRIP_CYCLES     = 4000,
    parameter int HOLDOFF_CYCLES  = 200,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    multi_zone_irrigation_ctrl_if.slave    io
);
    localparam int ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int NB = 3 + 3 * N_ZONES;
    // Level sensors come out of reset reading "full" so the inlet and alarm stay quiet.
    localparam logic [NB-1:0] SYNC_RST = {3'b111, {(3 * N_ZONES){1'b0}}};
    localparam logic [TIMER_W-1:0] SPR_T  = TIMER_W'(SPRINKLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DRIP_T = TIMER_W'(DRIP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_T = TIMER_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLDOFF, FAULT} state_e;

    logic [NB-1:0] raw, s1_q, s2_q, flt;

    assign raw = {io.high_level_indicator_i, io.middle_level_indicator_i, io.low_level_indicator_i,
                  io.soil_dry_i, io.temp_high_i, io.zone_enable_i};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= SYNC_RST;
            s2_q <= SYNC_RST;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [NB-1:0] db_q;
    logic [CW-1:0] cnt_q [NB];

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q <= SYNC_RST;
            for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (s2_q[b] == db_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[b]  <= s2_q[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign flt = db_q;
`else
    assign flt = s2_q;
`endif

    logic               hi, mid, lo, err;
    logic [N_ZONES-1:0] dry, temp, en, req;

    assign hi   = flt[NB-1];
    assign mid  = flt[NB-2];
    assign lo   = flt[NB-3];
    assign dry  = flt[3*N_ZONES-1 -: N_ZONES];
    assign temp = flt[2*N_ZONES-1 -: N_ZONES];
    assign en   = flt[N_ZONES-1:0];
    assign req  = dry & en;
    assign err  = (hi & ~mid) | (hi & ~lo) | (mid & ~lo);

    state_e             state_q, state_d;
    logic [ZW-1:0]      zone_q, zone_d, ptr_q, ptr_d, off, pick, zone_nxt;
    logic [ZW:0]        pick_sum;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               drip_q, drip_d, clean_q, clean_d;
    logic [2*N_ZONES-1:0] req2, rot;

    // Rotating the doubled request vector puts the pointer zone at bit 0.
    assign req2 = {req, req};
    assign rot  = req2 >> ptr_q;

    always_comb begin
        off = '0;
        for (int i = N_ZONES - 1; i >= 0; i--) begin
            if (rot[i]) off = ZW'(i);
        end
    end

    assign pick_sum = {1'b0, ptr_q} + {1'b0, off};
    assign pick     = (pick_sum >= (ZW + 1)'(N_ZONES)) ? ZW'(pick_sum - (ZW + 1)'(N_ZONES))
                                                       : pick_sum[ZW-1:0];
    assign zone_nxt = (zone_q == ZW'(N_ZONES - 1)) ? '0 : zone_q + 1'b1;

    always_comb begin
        state_d = state_q;
        zone_d  = zone_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        drip_d  = drip_q;
        clean_d = clean_q;
        if (err) begin
            state_d = FAULT;
            clean_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lo && |req) begin
                        state_d = RUN;
                        zone_d  = pick;
                        drip_d  = temp[pick];
                        timer_d = temp[pick] ? DRIP_T : SPR_T;
                    end
                end
                RUN: begin
                    if (!lo || !en[zone_q] || timer_q == '0) begin
                        state_d = HOLDOFF;
                        timer_d = HOLD_T;
                        ptr_d   = zone_nxt;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (timer_q == '0) state_d = IDLE;
                    else               timer_d = timer_q - 1'b1;
                end
                FAULT: begin
                    if (clean_q) begin
                        state_d = IDLE;
                        clean_d = 1'b0;
                    end else begin
                        clean_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic               inlet_q, inlet_d, err_q, alarm_q, busy_q, busy_d;
    logic [2:0]         act_q, act_d;
    logic [N_ZONES-1:0] spr_q, spr_d, dvl_q, dvl_d, vvec;

    always_comb begin
        inlet_d = inlet_q;
        if (state_d == FAULT) inlet_d = 1'b0;
        else if (!mid)        inlet_d = 1'b1;
        else if (hi)          inlet_d = 1'b0;
    end

    assign busy_d = (state_d == RUN);
    assign vvec   = busy_d ? (N_ZONES'(1) << zone_d) : '0;
    assign spr_d  = drip_d ? '0 : vvec;
    assign dvl_d  = drip_d ? vvec : '0;
    assign act_d  = busy_d ? 3'(zone_d) : 3'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            zone_q  <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            drip_q  <= 1'b0;
            clean_q <= 1'b0;
            inlet_q <= 1'b0;
            err_q   <= 1'b0;
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
            act_q   <= '0;
            spr_q   <= '0;
            dvl_q   <= '0;
        end else begin
            state_q <= state_d;
            zone_q  <= zone_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            drip_q  <= drip_d;
            clean_q <= clean_d;
            inlet_q <= inlet_d;
            err_q   <= err;
            alarm_q <= err | ~lo;
            busy_q  <= busy_d;
            act_q   <= act_d;
            spr_q   <= spr_d;
            dvl_q   <= dvl_d;
        end
    end

    assign io.inlet_valve_o     = inlet_q;
    assign io.error_indicator_o = err_q;
    assign io.alarm_state_o     = alarm_q;
    assign io.busy_o            = busy_q;
    assign io.active_zone_o     = act_q;
    assign io.sprinkler_valve_o = spr_q;
    assign io.drip_valve_o      = dvl_q;
endmodule

// File: tb/tb_multi_zone_irrigation_ctrl.sv
// Randomised and directed bench: a phase/countdown model of the scheduler predicts every output each cycle.
module tb_multi_zone_irrigation_ctrl;
    localparam int N    = 4;
    localparam int SPR  = 12;
    localparam int DRIP = 20;
    localparam int HOLD = 5;
    localparam int P_IDLE = 0, P_WATER = 1, P_REST = 2, P_FAULT = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multi_zone_irrigation_ctrl_if #(.N_ZONES(N)) bus ();

    multi_zone_irrigation_ctrl #(
        .N_ZONES(N), .TIMER_W(8), .SPRINKLE_CYCLES(SPR), .DRIP_CYCLES(DRIP),
        .HOLDOFF_CYCLES(HOLD), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .io(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]   lv;
        logic [N-1:0] dry;
        logic [N-1:0] temp;
        logic [N-1:0] en;
    } snap_t;

    snap_t hist[$];
    int    m_phase, m_zone, m_ptr, m_left, m_clean;
    bit    m_drip, m_inlet;
    logic [14:0] expv;

    function automatic logic [14:0] outs();
        return {bus.inlet_valve_o, bus.error_indicator_o, bus.alarm_state_o, bus.busy_o,
                bus.active_zone_o, bus.sprinkler_valve_o, bus.drip_valve_o};
    endfunction

    function automatic snap_t rst_snap();
        snap_t s;
        s.lv = 3'b111; s.dry = '0; s.temp = '0; s.en = '0;
        return s;
    endfunction

    // Reference: inputs reach the decision two edges late; a legal tank reads as a thermometer code.
    always @(posedge clk) begin : model
        snap_t cur, u;
        bit err, empty;
        logic [N-1:0] req, vv;
        int z;
        cur.lv   = {bus.high_level_indicator_i, bus.middle_level_indicator_i, bus.low_level_indicator_i};
        cur.dry  = bus.soil_dry_i;
        cur.temp = bus.temp_high_i;
        cur.en   = bus.zone_enable_i;
        if (reset) begin
            hist.delete();
            hist.push_back(rst_snap());
            hist.push_back(rst_snap());
            m_phase = P_IDLE; m_zone = 0; m_ptr = 0; m_left = 0; m_clean = 0;
            m_drip = 0; m_inlet = 0;
            expv = '0;
        end else begin
            u = hist.pop_front();
            hist.push_back(cur);
            err   = !(u.lv inside {3'b000, 3'b001, 3'b011, 3'b111});
            empty = !err && !u.lv[0];
            req   = u.dry & u.en;
            if (err) begin
                m_phase = P_FAULT;
                m_clean = 0;
            end else begin
                case (m_phase)
                    P_IDLE: if (!empty && req != 0) begin
                        z = -1;
                        for (int i = 0; i < N; i++)
                            if (z < 0 && req[(m_ptr + i) % N]) z = (m_ptr + i) % N;
                        m_zone  = z;
                        m_drip  = u.temp[z];
                        m_left  = m_drip ? DRIP : SPR;
                        m_phase = P_WATER;
                    end
                    P_WATER: begin
                        if (empty || !u.en[m_zone]) m_left = 0;
                        else m_left--;
                        if (m_left == 0) begin
                            m_phase = P_REST;
                            m_left  = HOLD;
                            m_ptr   = (m_zone + 1) % N;
                        end
                    end
                    P_REST: begin
                        m_left--;
                        if (m_left == 0) m_phase = P_IDLE;
                    end
                    default: begin
                        m_clean++;
                        if (m_clean == 2) begin
                            m_phase = P_IDLE;
                            m_clean = 0;
                        end
                    end
                endcase
            end
            if (m_phase == P_FAULT) m_inlet = 0;
            else if (!u.lv[1])      m_inlet = 1;
            else if (u.lv[2])       m_inlet = 0;
            vv = (m_phase == P_WATER) ? (N'(1) << m_zone) : '0;
            expv = {m_inlet, err, err || !u.lv[0], m_phase == P_WATER,
                    (m_phase == P_WATER) ? 3'(m_zone) : 3'd0,
                    m_drip ? '0 : vv, m_drip ? vv : '0};
        end
    end

    always @(negedge clk) begin : compare
        logic [14:0] act;
        act = outs();
        checks++;
        if (act !== expv) begin
            failures++;
            if (failures < 30)
                $display("FAIL model_outputs t=%0t got=%b expected=%b", $time, act, expv);
        end
        checks++;
        if ((bus.sprinkler_valve_o & bus.drip_valve_o) !== '0) begin
            failures++;
            $display("FAIL valve_exclusive t=%0t spr=%b drip=%b expected no overlap",
                     $time, bus.sprinkler_valve_o, bus.drip_valve_o);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pin(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic wait_busy(input logic want, input int budget, input string name, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (bus.busy_o === want) break;
        end
        checks++;
        if (bus.busy_o !== want) begin
            failures++;
            $display("FAIL %s timeout after %0d cycles busy=%b expected=%b", name, n, bus.busy_o, want);
        end
    endtask

    task automatic run_len(output int len);
        len = 1;
        while (len < 200) begin
            @(negedge clk);
            if (bus.busy_o === 1'b1) len++;
            else break;
        end
    endtask

    task automatic set_lv(input logic [2:0] lv);
        {bus.high_level_indicator_i, bus.middle_level_indicator_i, bus.low_level_indicator_i} = lv;
    endtask

    function automatic logic [2:0] rand_lv();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) return 3'b111;
        if (r < 65) return 3'b011;
        if (r < 80) return 3'b001;
        if (r < 90) return 3'b000;
        case ($urandom_range(0, 3))
            0:       return 3'b010;
            1:       return 3'b100;
            2:       return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, len;
        set_lv(3'b111);
        bus.soil_dry_i = '0; bus.temp_high_i = '0; bus.zone_enable_i = '1;
        reset = 1'b1;
        tick(3);
        pin("reset_outputs", int'(outs()), 0);
        reset = 1'b0;
        tick(10);
        pin("idle_inlet_closed", int'(bus.inlet_valve_o), 0);
        pin("idle_not_busy", int'(bus.busy_o), 0);

        bus.soil_dry_i = 4'b1010;
        wait_busy(1'b1, 10, "rr_first_grant", n);
        pin("rr_grant_latency", n, 3);
        pin("rr_first_sprinkler", int'(bus.sprinkler_valve_o), 4'b0010);
        pin("rr_first_zone_idx", int'(bus.active_zone_o), 1);
        run_len(len);
        pin("rr_sprinkle_len", len, SPR);
        wait_busy(1'b1, 30, "rr_second_grant", n);
        pin("rr_holdoff_gap", n, HOLD + 1);
        pin("rr_second_sprinkler", int'(bus.sprinkler_valve_o), 4'b1000);
        run_len(len);
        wait_busy(1'b1, 30, "rr_third_grant", n);
        pin("rr_third_sprinkler", int'(bus.sprinkler_valve_o), 4'b0010);
        bus.soil_dry_i = '0;
        run_len(len);
        pin("rr_dry_drop_len", len, SPR);
        tick(HOLD + 3);

        bus.temp_high_i = 4'b0100;
        bus.soil_dry_i  = 4'b0100;
        wait_busy(1'b1, 10, "drip_grant", n);
        pin("drip_valve", int'(bus.drip_valve_o), 4'b0100);
        pin("drip_no_sprinkler", int'(bus.sprinkler_valve_o), 0);
        bus.soil_dry_i = '0;
        run_len(len);
        pin("drip_len", len, DRIP);
        tick(HOLD + 3);
        bus.temp_high_i = '0;

        bus.soil_dry_i = 4'b0001;
        wait_busy(1'b1, 10, "wrap_grant", n);
        pin("wrap_sprinkler", int'(bus.sprinkler_valve_o), 4'b0001);
        tick(2);
        set_lv(3'b101);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.error_indicator_o !== 1'b1 && n < 10);
        pin("err_latency", n, 3);
        pin("err_alarm", int'(bus.alarm_state_o), 1);
        pin("err_valves_closed", int'(bus.sprinkler_valve_o | bus.drip_valve_o), 0);
        pin("err_inlet_closed", int'(bus.inlet_valve_o), 0);
        set_lv(3'b111);
        wait_busy(1'b1, 20, "fault_recover", n);
        pin("fault_recover_latency", n, 5);
        bus.soil_dry_i = '0;
        wait_busy(1'b0, 30, "fault_run_end", n);
        tick(HOLD + 3);

        bus.soil_dry_i = 4'b0001;
        wait_busy(1'b1, 10, "drain_grant", n);
        set_lv(3'b011);
        tick(3);
        pin("drain_mid_inlet", int'(bus.inlet_valve_o), 0);
        set_lv(3'b001);
        tick(3);
        pin("drain_low_inlet", int'(bus.inlet_valve_o), 1);
        pin("drain_low_busy", int'(bus.busy_o), 1);
        set_lv(3'b000);
        tick(3);
        pin("empty_alarm", int'(bus.alarm_state_o), 1);
        pin("empty_abort", int'(bus.busy_o), 0);
        pin("empty_inlet", int'(bus.inlet_valve_o), 1);
        tick(20);
        pin("empty_no_grant", int'(bus.busy_o), 0);
        bus.soil_dry_i = '0;
        set_lv(3'b001);
        tick(3);
        pin("refill_low_alarm", int'(bus.alarm_state_o), 0);
        set_lv(3'b011);
        tick(3);
        pin("refill_mid_inlet_hold", int'(bus.inlet_valve_o), 1);
        set_lv(3'b111);
        tick(3);
        pin("refill_full_inlet", int'(bus.inlet_valve_o), 0);
        tick(HOLD + 5);

        bus.soil_dry_i = 4'b0010;
        wait_busy(1'b1, 10, "reset_run_grant", n);
        tick(4);
        reset = 1'b1;
        tick(1);
        pin("reset_midrun_outputs", int'(outs()), 0);
        reset = 1'b0;
        bus.soil_dry_i = '0;
        tick(5);

        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            reset = 1'b0;
            if ($urandom_range(0, 7) == 0)   bus.soil_dry_i    = N'($urandom);
            if ($urandom_range(0, 15) == 0)  bus.zone_enable_i = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 15) == 0)  bus.temp_high_i   = N'($urandom);
            if ($urandom_range(0, 19) == 0)  set_lv(rand_lv());
            if ($urandom_range(0, 799) == 0) reset = 1'b1;
        end
        reset = 1'b0;
        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
